// File: rtl/dsm_dac_sample_sequencer.sv
// Sample sequencer for a 2nd-order delta-sigma DAC: sample FIFO, clk_en prescaler, per-sample dsm_in update.
// Optional soft-start ramp on stream start is enabled by defining DSM_SEQ_SOFT_START_EN.
module dsm_dac_sample_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [WIDTH-1:0]              s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [WIDTH-1:0]              dsm_in,
    output logic                          clk_en,
    output logic                          sample_tick,
    output logic                          underflow,
    output logic                          underflow_stk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    state
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int OW = $clog2(OSR);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // Handshake: a word transfers on a clock edge where s_valid & s_ready are both high;
    // s_ready depends only on FIFO fullness (no same-cycle pop bypass) and is low in reset.

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, STOP = 2'd3} state_t;
    state_t cur, nxt;

    logic [DW-1:0]    div_cnt;
    logic [OW-1:0]    osr_cnt;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic             full, empty, push, pop, flush, load, clear_out, en_q;
    logic [WIDTH-1:0] head, load_word;

    assign clk_en      = (div_cnt == DW'(CLK_DIV - 1));
    assign sample_tick = clk_en && (osr_cnt == OW'(OSR - 1));
    assign full        = (level == LW'(FIFO_DEPTH));
    assign empty       = (level == '0);
    assign s_ready     = rst && !full;
    assign push        = s_valid && s_ready;
    assign head        = mem[rd_ptr];
    assign fifo_level  = level;
    assign state       = cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            osr_cnt <= '0;
        end else begin
            div_cnt <= clk_en ? '0 : div_cnt + 1'b1;
            if (clk_en)
                osr_cnt <= (osr_cnt == OW'(OSR - 1)) ? '0 : osr_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt       = cur;
        pop       = 1'b0;
        flush     = 1'b0;
        load      = 1'b0;
        clear_out = 1'b0;
        underflow = 1'b0;
        case (cur)
            IDLE: if (enable) nxt = PRIME;
            PRIME: begin
                if (!enable) begin
                    nxt = IDLE;
                end else if (sample_tick && (level >= LW'(FIFO_DEPTH / 2))) begin
                    pop  = 1'b1;
                    load = 1'b1;
                    nxt  = RUN;
                end
            end
            RUN: begin
                if (sample_tick) begin
                    if (empty) begin
                        underflow = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end
                end
                if (!enable) nxt = STOP;
            end
            STOP: begin
                if (sample_tick) begin
                    flush     = 1'b1;
                    clear_out = 1'b1;
                    nxt       = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

`ifdef DSM_SEQ_SOFT_START_EN
    logic [2:0] shift, shift_nxt;

    // Ramp restarts at >>>4 on stream start; underflow ticks still step it down.
    always_comb begin
        shift_nxt = shift;
        if (cur == PRIME && load)
            shift_nxt = 3'd4;
        else if (cur == RUN && sample_tick && shift != 3'd0)
            shift_nxt = shift - 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) shift <= '0;
        else      shift <= shift_nxt;
    end

    assign load_word = WIDTH'($signed(head) >>> shift_nxt);
`else
    assign load_word = head;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur           <= IDLE;
            dsm_in        <= '0;
            en_q          <= 1'b0;
            underflow_stk <= 1'b0;
        end else begin
            cur  <= nxt;
            en_q <= enable;
            if (clear_out)  dsm_in <= '0;
            else if (load)  dsm_in <= load_word;
            // A new underflow in the same cycle as the enable edge keeps the flag set.
            if (underflow)                underflow_stk <= 1'b1;
            else if (enable && !en_q)     underflow_stk <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (flush) begin
                // A word accepted during the flush cycle survives it.
                rd_ptr <= wr_ptr;
                level  <= push ? LW'(1) : '0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dsm_dac_sample_sequencer.sv
// Directed bench for dsm_dac_sample_sequencer with CLK_DIV=4, OSR=8, FIFO_DEPTH=4 (32-clk sample period).
module tb_dsm_dac_sample_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] dsm_in;
    logic        clk_en, sample_tick, underflow, underflow_stk;
    logic [2:0]  fifo_level;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

`ifdef DSM_SEQ_SOFT_START_EN
    localparam logic [15:0] E1 = 16'h0100;
    localparam logic [15:0] E2 = 16'h0400;
    logic [15:0] exp_w [5] = '{16'h0400, 16'hF800, 16'h048D, 16'hC000, 16'h7FFF};
`else
    localparam logic [15:0] E1 = 16'h1000;
    localparam logic [15:0] E2 = 16'h2000;
    logic [15:0] exp_w [5] = '{16'h4000, 16'hC000, 16'h1234, 16'h8000, 16'h7FFF};
`endif
    logic [15:0] words [5] = '{16'h4000, 16'hC000, 16'h1234, 16'h8000, 16'h7FFF};

    always #5 clk = ~clk;

    dsm_dac_sample_sequencer #(
        .CLK_DIV(4), .OSR(8), .FIFO_DEPTH(4), .WIDTH(16)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .dsm_in(dsm_in), .clk_en(clk_en), .sample_tick(sample_tick),
        .underflow(underflow), .underflow_stk(underflow_stk),
        .fifo_level(fifo_level), .state(state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        checks++;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (sample_tick === 1'b1) return;
        end
        errors++;
        $display("FAIL wait_tick: no sample_tick within 100 cycles");
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (dsm_in !== 16'h0) begin errors++; $display("FAIL rst_dsm_in: got %h exp 0000", dsm_in); end
        checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL rst_clk_en: got %b exp 0", clk_en); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b exp 0", s_ready); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", state); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d exp 0", fifo_level); end
        checks++; if (underflow_stk !== 1'b0) begin errors++; $display("FAIL rst_stk: got %b exp 0", underflow_stk); end
        rst = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            checks++;
            if (clk_en !== (k % 4 == 3)) begin
                errors++; $display("FAIL prescale_clk_en k=%0d: got %b exp %b", k, clk_en, (k % 4 == 3));
            end
            checks++;
            if (sample_tick !== (k == 31)) begin
                errors++; $display("FAIL prescale_tick k=%0d: got %b exp %b", k, sample_tick, (k == 31));
            end
        end
        checks++; if (dsm_in !== 16'h0 || state !== 2'd0) begin
            errors++; $display("FAIL idle_out: dsm_in %h state %0d exp 0000/0", dsm_in, state);
        end
    endtask

    task automatic push_word(input logic [15:0] d);
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 100 && s_ready !== 1'b1; i++) step();
        step();
        s_valid = 1'b0;
    endtask

    task automatic test_prime_run();
        int n;
        enable = 1'b1;
        step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL prime_state: got %0d exp 1", state); end
        push_word(16'h1000);
        push_word(16'h2000);
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL prime_level: got %0d exp 2", fifo_level); end
        wait_tick(n);
        checks++; if (dsm_in !== 16'h0) begin errors++; $display("FAIL prime_hold: got %h exp 0000", dsm_in); end
        step();
        checks++; if (dsm_in !== E1) begin errors++; $display("FAIL first_word: got %h exp %h", dsm_in, E1); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL run_state: got %0d exp 2", state); end
        wait_tick(n);
        checks++; if (n !== 31) begin errors++; $display("FAIL period: got %0d exp 31", n); end
        checks++; if (dsm_in !== E1) begin errors++; $display("FAIL hold_first: got %h exp %h", dsm_in, E1); end
        step();
        checks++; if (dsm_in !== E2) begin errors++; $display("FAIL second_word: got %h exp %h", dsm_in, E2); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL run_level: got %0d exp 0", fifo_level); end
    endtask

    task automatic test_underflow_stop();
        int n;
        wait_tick(n);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_pulse: got %b exp 1", underflow); end
        checks++; if (underflow_stk !== 1'b0) begin errors++; $display("FAIL uf_stk_pre: got %b exp 0", underflow_stk); end
        step();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_pulse_end: got %b exp 0", underflow); end
        checks++; if (underflow_stk !== 1'b1) begin errors++; $display("FAIL uf_stk: got %b exp 1", underflow_stk); end
        checks++; if (dsm_in !== E2) begin errors++; $display("FAIL uf_hold: got %h exp %h", dsm_in, E2); end
        enable = 1'b0;
        step();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL stop_state: got %0d exp 3", state); end
        push_word(16'h5555);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL stop_push: got %0d exp 1", fifo_level); end
        wait_tick(n);
        checks++; if (dsm_in !== E2 || state !== 2'd3) begin
            errors++; $display("FAIL stop_hold: dsm_in %h state %0d exp %h/3", dsm_in, state, E2);
        end
        step();
        checks++; if (dsm_in !== 16'h0) begin errors++; $display("FAIL stop_zero: got %h exp 0000", dsm_in); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL stop_flush: got %0d exp 0", fifo_level); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL stop_idle: got %0d exp 0", state); end
        checks++; if (underflow_stk !== 1'b1) begin errors++; $display("FAIL stk_kept: got %b exp 1", underflow_stk); end
        enable = 1'b1;
        step();
        checks++; if (underflow_stk !== 1'b0) begin errors++; $display("FAIL stk_clear: got %b exp 0", underflow_stk); end
        enable = 1'b0;
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL back_idle: got %0d exp 0", state); end
    endtask

    task automatic test_fifo_full();
        int n;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = words[i];
            step();
        end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", s_ready); end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d exp 4", fifo_level); end
        s_data = words[4];
        repeat (3) step();
        checks++; if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin
            errors++; $display("FAIL full_held: level %0d ready %b exp 4/0", fifo_level, s_ready);
        end
        enable = 1'b1;
        wait_tick(n);
        checks++; if (state !== 2'd1 || s_ready !== 1'b0 || fifo_level !== 3'd4) begin
            errors++; $display("FAIL full_pop_cycle: state %0d ready %b level %0d exp 1/0/4", state, s_ready, fifo_level);
        end
        step();
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL pop_level: got %0d exp 3", fifo_level); end
        checks++; if (dsm_in !== exp_w[0]) begin errors++; $display("FAIL word0: got %h exp %h", dsm_in, exp_w[0]); end
        step();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fifth_push: got %0d exp 4", fifo_level); end
        s_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            wait_tick(n);
            checks++; if (n !== ((i == 1) ? 30 : 31)) begin
                errors++; $display("FAIL word%0d_period: got %0d exp %0d", i, n, (i == 1) ? 30 : 31);
            end
            checks++; if (dsm_in !== exp_w[i-1]) begin
                errors++; $display("FAIL word%0d_hold: got %h exp %h", i, dsm_in, exp_w[i-1]);
            end
            step();
            checks++; if (dsm_in !== exp_w[i]) begin errors++; $display("FAIL word%0d: got %h exp %h", i, dsm_in, exp_w[i]); end
            checks++; if (fifo_level !== 3'(4 - i)) begin
                errors++; $display("FAIL word%0d_level: got %0d exp %0d", i, fifo_level, 4 - i);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        repeat (5) step();
        rst = 1'b0;
        #1;
        checks++; if (dsm_in !== 16'h0) begin errors++; $display("FAIL mid_rst_dsm_in: got %h exp 0000", dsm_in); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d exp 0", state); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0", s_ready); end
        checks++; if (clk_en !== 1'b0 || sample_tick !== 1'b0) begin
            errors++; $display("FAIL mid_rst_strobes: clk_en %b tick %b exp 0/0", clk_en, sample_tick);
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level: got %0d exp 0", fifo_level); end
        enable = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++; if (s_ready !== 1'b1 || state !== 2'd0) begin
            errors++; $display("FAIL post_rst: ready %b state %0d exp 1/0", s_ready, state);
        end
    endtask

    initial begin
        test_reset();
        test_prime_run();
        test_underflow_stop();
        test_fifo_full();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
